pe_tile_param: RTL
==================

# pe_tile_param

Parametrised next-generation processing-element tile for the TinyFPGA array: four sides of `NUM_TRACKS` routing tracks, each `WIDTH` bits, a configurable switch box, two connect boxes feeding a multi-bit compute block, per-output pipeline registers, and registered configuration readback. It replaces the single-bit, 4-track, write-only tile in grid generation; the config addressing scheme (tile id in the low half, target in the upper half) is retained.

## Interface
Parameters:
- `WIDTH`, 1: data bits per track.
- `NUM_TRACKS`, 4: tracks per side; legal range 1..8.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `config_addr`, in, 32: [15:0] tile id match, [23:16] target, [31:24] word index.
- `config_data`, in, 32: write data.
- `config_we`, in, 1: write strobe.
- `config_rd`, in, 1: read strobe.
- `tile_id`, in, 16: this tile's id.
- `in_tracks`, in, 4·NUM_TRACKS·WIDTH: side s, track t at bits [(s·NUM_TRACKS+t)·WIDTH +: WIDTH].
- `out_tracks`, out, 4·NUM_TRACKS·WIDTH: same packing.
- `config_rdata`, out, 32: readback data.
- `config_rvalid`, out, 1: one-cycle readback pulse.

## Operation
- Target codes: SB=7, CB0=6, CB1=5, CLB=4, OUTREG=3. A write or read is selected when addr[15:0]==tile_id and the target is valid.
- SB: each output (s,t) has a 2-bit select; 0 selects pe_output, k=1..3 selects in_tracks side (s+k)%4, track t. Selects pack 16 per word; output index i=s·NUM_TRACKS+t lives in word i/16, bits [2·(i%16)+:2]. SB_WORDS = ceil(4·NUM_TRACKS/16).
- CB0 and CB1: the select occupies config_data[CB_W-1:0], where CB_W = clog2(2·NUM_TRACKS). For select j < NUM_TRACKS, the source is in_tracks of side 0 (CB0) or side 1 (CB1), track j. For select j ≥ NUM_TRACKS, the source is out_tracks of the same side, track j−NUM_TRACKS. Out-of-range selects yield 0.
- CLB: config_data[2:0] sets op:
  - 0 AND, 1 OR, 2 XOR, 3 ADD mod 2^WIDTH, 4 SUB mod 2^WIDTH (op_0−op_1), 5 pass op_0, 6 NOT op_0, 7 zero.
  - config_data[3]=1 registers pe_output (one-cycle delay); 0 makes it combinational.
- OUTREG: config_data bit i=1 makes output i registered; 0 makes it combinational from the SB mux.
- Writes apply at the clock edge and take effect in the cycle that follows. Word index is ignored except for SB. Writes to an unmapped target or an SB word ≥ SB_WORDS are dropped.
- Readback: a selected config_rd gives config_rvalid=1 next cycle, with config_rdata holding the stored word, zero-extended. An unmapped target or out-of-range word still returns rvalid=1 with rdata=0. An unselected read gives rvalid=0 and rdata=0.
- Simultaneous we+rd to the same word: write is applied; rdata returns the pre-write value.
- Combinational loops through CB→CLB→SB are a software error unless either the CLB output or the OUTREG path is registered.

## Timing
- Reset sets every config register to 0, every pipeline register and the CLB register to 0, and config_rvalid and config_rdata to 0. Reset beats a write or read in the same cycle.
- Reset config state:
  - all SB selects = pe_output;
  - CBs select in track 0;
  - CLB AND, combinational;
  - no output registers.
- Combinational path: out_tracks follows in_tracks in the same cycle.
- Registered path: each register adds exactly one cycle, and the two add: CLB reg + OUTREG = 2 cycles from a CB input to a tile output.
- Readback latency is 1 cycle. Back-to-back reads give back-to-back rvalid.

## Structure
- Shared header `pe_tile_defs.vh`, include-guarded, holds the target codes, CLB op codes, and SB select encoding.
- One sub-module, `pe_tile_sb`, parametrised by WIDTH and NUM_TRACKS. It contains the SB mux array and the OUTREG pipeline registers.
- Connect boxes, CLB, config decode and readback are inline in `pe_tile_param`.

## Test plan
- NUM_TRACKS=4, WIDTH=8, after reset: drive in_tracks side 0 track 0 = 0x0F and side 1 track 0 = 0x0F → every output = 0x0F (AND) in the same cycle.
- Write CLB op 3 with data[3]=1; CB0 sel 1, CB1 sel 2; inputs 0x7F and 0x02 → outputs 0x81 one cycle later. Then 0xFF and 0x02 → 0x01 (wrap).
- Write SB word 0 = 0x0000_0001 (output 0 selects side 1 track 0) and OUTREG = 0x1; toggle in side 1 track 0 → out (0,0) follows one cycle late while other outputs still show pe_output.
- Write SB word 0 with tile_id mismatch → no change. Read with matching addr → rvalid next cycle, rdata = old word. Read SB word 5 → rvalid=1, rdata=0.
- Same cycle we+rd to CB0 (old 1, new 3) → rdata=1 and later reads =3. Assert reset with we → register stays 0 and rvalid=0.
- NUM_TRACKS=8, WIDTH=1: SB_WORDS=2. Write word 1 bits [1:0]=2 → output 16 (side 2, track 0) = in side 0 track 0.

Source files
------------

// File: rtl/pe_tile_param_pkg.sv
// Package wrapper so the tile encodings are imported rather than textually repeated.
package pe_tile_param_pkg;
`include "pe_tile_defs.vh"
endpackage

// File: rtl/pe_tile_defs.vh
// Shared encodings for the PE tile: config target codes, CLB op codes, SB select values.
`ifndef PE_TILE_DEFS_VH
`define PE_TILE_DEFS_VH

localparam logic [7:0] TGT_SB     = 8'd7;
localparam logic [7:0] TGT_CB0    = 8'd6;
localparam logic [7:0] TGT_CB1    = 8'd5;
localparam logic [7:0] TGT_CLB    = 8'd4;
localparam logic [7:0] TGT_OUTREG = 8'd3;

localparam logic [2:0] OP_AND  = 3'd0;
localparam logic [2:0] OP_OR   = 3'd1;
localparam logic [2:0] OP_XOR  = 3'd2;
localparam logic [2:0] OP_ADD  = 3'd3;
localparam logic [2:0] OP_SUB  = 3'd4;
localparam logic [2:0] OP_PASS = 3'd5;
localparam logic [2:0] OP_NOT  = 3'd6;
localparam logic [2:0] OP_ZERO = 3'd7;

// SB select 0 picks the CLB output; k=1..3 picks side (s+k)%4, same track.
localparam logic [1:0] SB_SEL_PE   = 2'd0;
localparam int         SB_PER_WORD = 16;

`endif

// File: rtl/pe_tile_sb.sv
// Switch box mux array plus optional per-output pipeline register.
// Latency 0 or 1 cycle per output; no backpressure.
module pe_tile_sb
    import pe_tile_param_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int NUM_TRACKS = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [8*NUM_TRACKS-1:0]        sel_i,
    input  logic [4*NUM_TRACKS-1:0]        outreg_i,
    input  logic [WIDTH-1:0]               pe_out_i,
    input  logic [WIDTH-1:0]               pe_fb_i,
    input  logic [4*NUM_TRACKS*WIDTH-1:0]  in_tracks_i,
    output logic [4*NUM_TRACKS*WIDTH-1:0]  out_tracks_o,
    output logic [2*NUM_TRACKS*WIDTH-1:0]  fb_tracks_o
);
    localparam int NOUT = 4 * NUM_TRACKS;
    localparam int TW   = NOUT * WIDTH;

    logic [TW-1:0] pipe_d;
    logic [TW-1:0] pipe_q;

    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_trk
            localparam int I = s * NUM_TRACKS + t;
            logic [1:0]       sel;
            logic [WIDTH-1:0] in_sel;

            assign sel    = sel_i[2*I +: 2];
            assign in_sel = (sel == 2'd1) ? in_tracks_i[(((s+1)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH] :
                            (sel == 2'd2) ? in_tracks_i[(((s+2)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH] :
                                            in_tracks_i[(((s+3)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
            assign pipe_d[I*WIDTH +: WIDTH]       = (sel == SB_SEL_PE) ? pe_out_i : in_sel;
            assign out_tracks_o[I*WIDTH +: WIDTH] = outreg_i[I] ? pipe_q[I*WIDTH +: WIDTH]
                                                                : pipe_d[I*WIDTH +: WIDTH];

            // Copy of sides 0/1 for the connect boxes: a combinational CLB seen through a
            // combinational output is an illegal loop, so it is replaced by zero there.
            if (s < 2) begin : g_fb
                assign fb_tracks_o[I*WIDTH +: WIDTH] = outreg_i[I] ? pipe_q[I*WIDTH +: WIDTH] :
                                                       (sel == SB_SEL_PE) ? pe_fb_i : in_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end
endmodule

// File: rtl/pe_tile_param.sv
// Parametrised PE tile: config decode/readback, two connect boxes, CLB, switch box.
// Data latency 0-2 cycles by config; readback 1 cycle; no backpressure.
module pe_tile_param
    import pe_tile_param_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int NUM_TRACKS = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    config_addr,
    input  logic [31:0]                    config_data,
    input  logic                           config_we,
    input  logic                           config_rd,
    input  logic [15:0]                    tile_id,
    input  logic [4*NUM_TRACKS*WIDTH-1:0]  in_tracks,
    output logic [4*NUM_TRACKS*WIDTH-1:0]  out_tracks,
    output logic [31:0]                    config_rdata,
    output logic                           config_rvalid
);
    localparam int NOUT = 4 * NUM_TRACKS;
    localparam int CB_W = $clog2(2 * NUM_TRACKS);

    logic [7:0]              cfg_tgt;
    logic [7:0]              cfg_word;
    logic                    cfg_hit;
    logic [2*NOUT-1:0]       sb_sel_d, sb_sel_q;
    logic [CB_W-1:0]         cb0_d, cb0_q, cb1_d, cb1_q;
    logic [3:0]              clb_cfg_d, clb_cfg_q;
    logic [NOUT-1:0]         outreg_d, outreg_q;
    logic [31:0]             rdata_d, rdata_q;
    logic                    rvalid_d, rvalid_q;
    logic [WIDTH-1:0]        op0, op1, clb_res, clb_q, pe_out, pe_fb;
    logic [2*NUM_TRACKS*WIDTH-1:0] fb_tracks;

    assign cfg_tgt  = config_addr[23:16];
    assign cfg_word = config_addr[31:24];
    assign cfg_hit  = (config_addr[15:0] == tile_id);

    always_comb begin
        sb_sel_d  = sb_sel_q;
        cb0_d     = cb0_q;
        cb1_d     = cb1_q;
        clb_cfg_d = clb_cfg_q;
        outreg_d  = outreg_q;
        if (config_we && cfg_hit) begin
            case (cfg_tgt)
                TGT_SB: begin
                    for (int i = 0; i < NOUT; i++) begin
                        if (i / SB_PER_WORD == int'(cfg_word)) begin
                            sb_sel_d[2*i +: 2] = config_data[2*(i%SB_PER_WORD) +: 2];
                        end
                    end
                end
                TGT_CB0:    cb0_d     = config_data[CB_W-1:0];
                TGT_CB1:    cb1_d     = config_data[CB_W-1:0];
                TGT_CLB:    clb_cfg_d = config_data[3:0];
                TGT_OUTREG: outreg_d  = config_data[NOUT-1:0];
                default: ;
            endcase
        end
    end

    // Readback samples the pre-write registers, so a same-cycle write returns the old word.
    always_comb begin
        rvalid_d = config_rd && cfg_hit;
        rdata_d  = '0;
        if (rvalid_d) begin
            case (cfg_tgt)
                TGT_SB: begin
                    for (int i = 0; i < NOUT; i++) begin
                        if (i / SB_PER_WORD == int'(cfg_word)) begin
                            rdata_d[2*(i%SB_PER_WORD) +: 2] = sb_sel_q[2*i +: 2];
                        end
                    end
                end
                TGT_CB0:    rdata_d[CB_W-1:0] = cb0_q;
                TGT_CB1:    rdata_d[CB_W-1:0] = cb1_q;
                TGT_CLB:    rdata_d[3:0]      = clb_cfg_q;
                TGT_OUTREG: rdata_d[NOUT-1:0] = outreg_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        op0 = '0;
        op1 = '0;
        for (int j = 0; j < NUM_TRACKS; j++) begin
            if (int'(cb0_q) == j)              op0 = in_tracks[j*WIDTH +: WIDTH];
            if (int'(cb0_q) == j + NUM_TRACKS) op0 = fb_tracks[j*WIDTH +: WIDTH];
            if (int'(cb1_q) == j)              op1 = in_tracks[(NUM_TRACKS+j)*WIDTH +: WIDTH];
            if (int'(cb1_q) == j + NUM_TRACKS) op1 = fb_tracks[(NUM_TRACKS+j)*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        clb_res = '0;
        case (clb_cfg_q[2:0])
            OP_AND:  clb_res = op0 & op1;
            OP_OR:   clb_res = op0 | op1;
            OP_XOR:  clb_res = op0 ^ op1;
            OP_ADD:  clb_res = op0 + op1;
            OP_SUB:  clb_res = op0 - op1;
            OP_PASS: clb_res = op0;
            OP_NOT:  clb_res = ~op0;
            OP_ZERO: clb_res = '0;
        endcase
    end

    assign pe_out = clb_cfg_q[3] ? clb_q : clb_res;
    assign pe_fb  = clb_cfg_q[3] ? clb_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_sel_q  <= '0;
            cb0_q     <= '0;
            cb1_q     <= '0;
            clb_cfg_q <= '0;
            outreg_q  <= '0;
            clb_q     <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            sb_sel_q  <= sb_sel_d;
            cb0_q     <= cb0_d;
            cb1_q     <= cb1_d;
            clb_cfg_q <= clb_cfg_d;
            outreg_q  <= outreg_d;
            clb_q     <= clb_res;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign config_rdata  = rdata_q;
    assign config_rvalid = rvalid_q;

    pe_tile_sb #(
        .WIDTH      (WIDTH),
        .NUM_TRACKS (NUM_TRACKS)
    ) u_sb (
        .clk          (clk),
        .reset        (reset),
        .sel_i        (sb_sel_q),
        .outreg_i     (outreg_q),
        .pe_out_i     (pe_out),
        .pe_fb_i      (pe_fb),
        .in_tracks_i  (in_tracks),
        .out_tracks_o (out_tracks),
        .fb_tracks_o  (fb_tracks)
    );
endmodule
